dft_frame_serializer: RTL and testbench

- Output-side companion to the parallel DFT stage; it reads the N-word frame that stage writes.
- Captures one N-word frame in a single-cycle parallel transfer, then streams it out one word per handshake with valid/ready flow control.
- Undoes the DFT's bit-reversed bin ordering, so downstream logic (magnitude, UART/debug readout) sees bins in natural order 0..N-1.
- Supports back-to-back frames with no idle cycle between them.

---
 rtl/dft_frame_serializer.sv | 115 +++++++++++
 tb/tb_dft_frame_serializer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dft_frame_serializer.sv
// Frame-to-word serializer for the parallel DFT stage: captures N words in one
// transfer, streams them out with valid/ready. Macro DFT_SER_BITREV_EN enables bit-reversed slot addressing.
`timescale 1ns/1ps

module dft_frame_serializer #(
  parameter int N       = 8,
  parameter int WORD_SZ = 8,
  parameter int IDX_W   = $clog2(N)
) (
  input  logic                   i_CLK,
  input  logic                   i_RESET,
  input  logic [N*WORD_SZ-1:0]   i_frame,
  input  logic                   i_frame_valid,
  output logic                   o_frame_ready,
  output logic [WORD_SZ-1:0]     o_word,
  output logic                   o_word_valid,
  input  logic                   i_word_ready,
  output logic [IDX_W-1:0]       o_word_idx,
  output logic                   o_last
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   k_q, k_d;
  logic [WORD_SZ-1:0] buffer [N];

  logic last_k;
  logic word_acc;
  logic frame_ready_raw;
  logic frame_acc;

  // Buffer slot holding natural-order bin k.
  function automatic logic [IDX_W-1:0] slot_of(input logic [IDX_W-1:0] k);
    logic [IDX_W-1:0] r;
`ifdef DFT_SER_BITREV_EN
    for (int i = 0; i < IDX_W; i++) r[i] = k[IDX_W-1-i];
`else
    r = k;
`endif
    return r;
  endfunction

  assign last_k          = (k_q == IDX_W'(N - 1));
  assign word_acc        = (state_q == STREAM) && i_word_ready;
  // The last word and the next frame can trade places on one edge.
  assign frame_ready_raw = (state_q == IDLE) || (state_q == STREAM && last_k && i_word_ready);
  assign frame_acc       = i_frame_valid && frame_ready_raw;
  assign o_frame_ready   = frame_ready_raw && i_RESET;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (frame_acc) begin
          state_d = STREAM;
          k_d     = '0;
        end
      end
      STREAM: begin
        if (frame_acc) begin
          k_d = '0;
        end else if (word_acc) begin
          if (last_k) begin
            state_d = IDLE;
            k_d     = '0;
          end else begin
            k_d = k_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // the same pre-edge values regardless of block ordering.
  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // NOTE: the frame buffer is reset explicitly, so it must map to flops rather
  // than a RAM macro; N is small enough that this is intended.
  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      for (int s = 0; s < N; s++) buffer[s] <= '0;
    end else if (frame_acc) begin
      for (int s = 0; s < N; s++) buffer[s] <= i_frame[s*WORD_SZ +: WORD_SZ];
    end
  end

  assign o_word_valid = (state_q == STREAM);
  assign o_word       = o_word_valid ? buffer[slot_of(k_q)] : '0;
  assign o_word_idx   = k_q;
  assign o_last       = o_word_valid && last_k;

  stall_hold_a: assert property (@(posedge i_CLK) disable iff (!i_RESET)
    (o_word_valid && !i_word_ready) |=>
      (o_word_valid && $stable(o_word) && $stable(o_word_idx) && $stable(o_last)));

endmodule

// File: tb/tb_dft_frame_serializer.sv
// Self-checking bench for dft_frame_serializer (N=4): queue-based reference model
// checked every cycle, directed literal scenarios, then randomized traffic.
`timescale 1ns/1ps

module tb_dft_frame_serializer;

  localparam int N       = 4;
  localparam int WORD_SZ = 8;
  localparam int IDX_W   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N*WORD_SZ-1:0] frame = '0;
  logic                 frame_valid = 1'b0;
  logic                 frame_ready;
  logic [WORD_SZ-1:0]   word;
  logic                 word_valid;
  logic                 word_ready = 1'b0;
  logic [IDX_W-1:0]     word_idx;
  logic                 last;

  dft_frame_serializer #(.N(N), .WORD_SZ(WORD_SZ)) dut (
    .i_CLK         (clk),
    .i_RESET       (rst_n),
    .i_frame       (frame),
    .i_frame_valid (frame_valid),
    .o_frame_ready (frame_ready),
    .o_word        (word),
    .o_word_valid  (word_valid),
    .i_word_ready  (word_ready),
    .o_word_idx    (word_idx),
    .o_last        (last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WORD_SZ-1:0] w;
    logic [IDX_W-1:0]   idx;
    logic               lst;
  } beat_t;

  beat_t exp_q[$];
  beat_t cap_q[$];
  bit    frame_taken = 1'b0;
  int    n_vec  = 0;
  int    n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bitrev(input int k);
    int r = 0;
`ifdef DFT_SER_BITREV_EN
    for (int i = 0; i < IDX_W; i++) if ((k >> i) & 1) r += 1 << (IDX_W - 1 - i);
`else
    r = k;
`endif
    return r;
  endfunction

  // Reference: a frame becomes N queued beats; ready when nothing is left to
  // send, or only the last beat remains and it is being taken now.
  function automatic bit model_ready();
    return (exp_q.size() == 0) || (exp_q.size() == 1 && word_ready);
  endfunction

  always @(posedge clk) begin
    bit rdy;
    if (!rst_n) begin
      exp_q.delete();
      frame_taken = 1'b0;
    end else begin
      rdy = model_ready();
      frame_taken = frame_valid && rdy;
      if (exp_q.size() != 0 && word_ready) void'(exp_q.pop_front());
      if (frame_taken) begin
        for (int k = 0; k < N; k++) begin
          beat_t b;
          b.w   = frame[bitrev(k)*WORD_SZ +: WORD_SZ];
          b.idx = IDX_W'(k);
          b.lst = (k == N - 1);
          exp_q.push_back(b);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_word_valid", word_valid, 0);
      check("rst_frame_ready", frame_ready, 0);
      check("rst_word", word, 0);
      check("rst_last", last, 0);
    end else begin
      check("frame_ready", frame_ready, model_ready());
      check("word_valid", word_valid, exp_q.size() != 0);
      if (exp_q.size() != 0 && word_valid) begin
        check("word", word, exp_q[0].w);
        check("word_idx", word_idx, exp_q[0].idx);
        check("last", last, exp_q[0].lst);
        if (word_ready) begin
          beat_t b;
          b.w = word; b.idx = word_idx; b.lst = last;
          cap_q.push_back(b);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer a frame and hold it until the model reports acceptance.
  task automatic send_frame(input logic [N*WORD_SZ-1:0] f, output int waited);
    frame = f;
    frame_valid = 1'b1;
    waited = 0;
    do begin
      cyc();
      waited++;
    end while (!frame_taken && waited < 50);
    if (!frame_taken) check("frame_accept_timeout", 0, 1);
    frame_valid = 1'b0;
  endtask

  logic [WORD_SZ-1:0] exp_words [N];
  int waited;
  bit offering;

  initial begin
`ifdef DFT_SER_BITREV_EN
    exp_words = '{8'h10, 8'h12, 8'h11, 8'h13};
`else
    exp_words = '{8'h10, 8'h11, 8'h12, 8'h13};
`endif
    #2;
    check("reset_frame_ready_gated", frame_ready, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    #1;
    check("post_reset_frame_ready", frame_ready, 1);
    check("post_reset_word_valid", word_valid, 0);
    check("post_reset_word_idx", word_idx, 0);

    // Single frame, free-running sink.
    cap_q.delete();
    word_ready = 1'b1;
    send_frame(32'h1312_1110, waited);
    repeat (5) cyc();
    check("t1_count", cap_q.size(), 4);
    for (int i = 0; i < N && i < cap_q.size(); i++) begin
      check("t1_word", cap_q[i].w, exp_words[i]);
      check("t1_idx", cap_q[i].idx, i);
      check("t1_last", cap_q[i].lst, i == N - 1);
    end
    check("t1_idle_ready", frame_ready, 1);

    // Back-to-back: second frame taken with the last word, no bubble.
    cap_q.delete();
    send_frame(32'h1312_1110, waited);
    send_frame(32'h2322_2120, waited);
    check("b2b_accept_delay", waited, 4);
    check("b2b_bin0_word", word, 8'h20);
    check("b2b_bin0_idx", word_idx, 0);
    check("b2b_bin0_valid", word_valid, 1);
    repeat (5) cyc();
    check("b2b_count", cap_q.size(), 8);
    if (cap_q.size() == 8) begin
      check("b2b_w3", cap_q[3].w, 8'h13);
      check("b2b_w4", cap_q[4].w, 8'h20);
    end

    // Backpressure on bin 1.
    cap_q.delete();
    send_frame(32'h1312_1110, waited);
    cyc();
    word_ready = 1'b0;
    repeat (3) begin
      check("stall_word", word, exp_words[1]);
      check("stall_idx", word_idx, 1);
      check("stall_valid", word_valid, 1);
      cyc();
    end
    word_ready = 1'b1;
    repeat (4) cyc();
    check("stall_count", cap_q.size(), 4);
    for (int i = 0; i < N && i < cap_q.size(); i++) check("stall_seq", cap_q[i].w, exp_words[i]);

    // Reset mid-stream after bins 0 and 1 transfer.
    cap_q.delete();
    send_frame(32'h1312_1110, waited);
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", word_valid, 0);
    check("midrst_frame_ready", frame_ready, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    check("midrst_partial_count", cap_q.size(), 2);
    check("midrst_release_ready", frame_ready, 1);
    cap_q.delete();
    send_frame(32'h3332_3130, waited);
    repeat (5) cyc();
    check("midrst_new_count", cap_q.size(), 4);
    if (cap_q.size() > 0) check("midrst_new_bin0", cap_q[0].w, 8'h30);

    // Randomized traffic with backpressure and occasional reset.
    offering = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (frame_taken) offering = 1'b0;
      if (!offering && ($urandom_range(2) == 0)) begin
        offering = 1'b1;
        frame = {$urandom, $urandom} >> 32;
      end
      frame_valid = offering;
      word_ready  = ($urandom_range(3) != 0);
      if ($urandom_range(299) == 0) begin
        rst_n = 1'b0;
        offering = 1'b0;
        frame_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
      end
      cyc();
    end

    // Saturated throughput: sink always ready, source always offering.
    word_ready = 1'b1;
    cap_q.delete();
    for (int c = 0; c < 200; c++) begin
      if (frame_taken || !frame_valid) frame = $urandom;
      frame_valid = 1'b1;
      cyc();
    end
    frame_valid = 1'b0;
    check("throughput_words", cap_q.size() >= 196, 1);
    repeat (6) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
